// File: rtl/sobel_mdc_out_packer.sv
// Packs one pixel per input word into four-lane output words with byte strobes and an end-of-frame flag.
// Optional macro SOBEL_MDC_PACK_SAT_EN: clamp the signed input word to [0,255] instead of truncating it.
module sobel_mdc_out_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int PIX_WIDTH  = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [LEN_WIDTH-1:0]    frame_len_i,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o,
    output logic                    out_last_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int LANES  = DATA_WIDTH / PIX_WIDTH;
    localparam int LANE_W = $clog2(LANES);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LANE_W-1:0]     lane_cnt_q, lane_cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [STRB_W-1:0]     out_strb_q, out_strb_d;
    logic                  out_last_q, out_last_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;

    logic [PIX_WIDTH-1:0]  pix;
    logic [DATA_WIDTH-1:0] merged;
    logic [STRB_W-1:0]     strb_mask;
    logic                  in_ready;
    logic                  in_fire;
    logic                  out_fire;
    logic                  is_last;
    logic                  complete;

`ifdef SOBEL_MDC_PACK_SAT_EN
    function automatic logic [PIX_WIDTH-1:0] sat_pixel(input logic signed [DATA_WIDTH-1:0] word);
        if (word[DATA_WIDTH-1]) begin
            return '0;
        end else if (|word[DATA_WIDTH-2:PIX_WIDTH]) begin
            return '1;
        end else begin
            return word[PIX_WIDTH-1:0];
        end
    endfunction

    assign pix = sat_pixel($signed(in_data_i));
`else
    logic unused_upper;
    assign unused_upper = ^in_data_i[DATA_WIDTH-1:PIX_WIDTH];
    assign pix          = in_data_i[PIX_WIDTH-1:0];
`endif

    // Accepting a pixel needs room in the output register, or that it empties this cycle.
    assign in_ready = (state_q == PACK) && (!out_valid_q || out_ready_i);
    assign in_fire  = in_valid_i && in_ready;
    assign out_fire = out_valid_q && out_ready_i;
    assign is_last  = (pix_cnt_q == len_q - LEN_WIDTH'(1));
    assign complete = (lane_cnt_q == LANE_W'(LANES - 1)) || is_last;

    always_comb begin
        merged    = acc_q;
        strb_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt_q == LANE_W'(k)) begin
                merged[k*PIX_WIDTH +: PIX_WIDTH] = pix;
            end
        end
        for (int k = 0; k < STRB_W; k++) begin
            strb_mask[k] = (LANE_W'(k) <= lane_cnt_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pix_cnt_d   = pix_cnt_q;
        lane_cnt_d  = lane_cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (frame_len_i != '0) begin
                        len_d      = frame_len_i;
                        pix_cnt_d  = '0;
                        lane_cnt_d = '0;
                        acc_d      = '0;
                        state_d    = PACK;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            PACK: begin
                if (in_fire) begin
                    pix_cnt_d  = pix_cnt_q + LEN_WIDTH'(1);
                    lane_cnt_d = lane_cnt_q + LANE_W'(1);
                    if (complete) begin
                        // Loading here overrides the drop of out_valid from a same-cycle handshake.
                        out_data_d  = merged;
                        out_strb_d  = strb_mask;
                        out_last_d  = is_last;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        lane_cnt_d  = '0;
                    end else begin
                        acc_d = merged;
                    end
                    if (is_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            len_q       <= '0;
            pix_cnt_q   <= '0;
            lane_cnt_q  <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pix_cnt_q   <= pix_cnt_d;
            lane_cnt_q  <= lane_cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_data_o  = out_data_q;
    assign out_strb_o  = out_strb_q;
    assign out_last_o  = out_last_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

endmodule
